// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   N-to-1 arbitrating multiplexer with one output register stage.
//   Several valid/ready producers share one valid/ready consumer. One channel
//   is granted per cycle. Selection is round-robin (MODE=0) or fixed priority
//   with the lowest index winning (MODE=1).
//
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active high
//   vld_i  : [CH_NUM] per-channel valid
//   dat_i  : [CH_NUM][DAT_WIDTH] per-channel data
//   rdy_o  : [CH_NUM] per-channel ready (combinational, at most one bit set)
//   vld_o  : registered output valid
//   dat_o  : registered output data
//   ch_o   : registered index of the channel that produced dat_o
//   rdy_i  : downstream ready
module rr_arb_mux #(
   parameter int CH_NUM    = 4,
   parameter int DAT_WIDTH = 8,
   parameter int MODE      = 0,
   parameter int SEL_WIDTH = $clog2(CH_NUM)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [CH_NUM-1:0]                vld_i,
   input  logic [CH_NUM-1:0][DAT_WIDTH-1:0] dat_i,
   output logic [CH_NUM-1:0]                rdy_o,
   output logic                             vld_o,
   output logic [DAT_WIDTH-1:0]             dat_o,
   output logic [SEL_WIDTH-1:0]             ch_o,
   input  logic                             rdy_i
);

   logic [SEL_WIDTH-1:0] ptr;
   logic [SEL_WIDTH-1:0] grant;
   logic [SEL_WIDTH-1:0] grant_lo;
   logic [SEL_WIDTH-1:0] grant_hi;
   logic                 found_lo;
   logic                 found_hi;
   logic                 any_vld;
   logic                 load;

   assign any_vld = |vld_i;
   // Register is free when empty or being drained on this edge.
   assign load    = !vld_o || rdy_i;

   // Two priority searches: lowest valid overall, and lowest valid at or
   // above ptr. The round-robin winner is the upper hit when one exists,
   // otherwise the search wraps to the lowest valid index.
   always_comb begin
      grant_lo = '0;
      found_lo = 1'b0;
      grant_hi = '0;
      found_hi = 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (vld_i[k] && !found_lo) begin
            grant_lo = SEL_WIDTH'(k);
            found_lo = 1'b1;
         end
         if (vld_i[k] && !found_hi && (SEL_WIDTH'(k) >= ptr)) begin
            grant_hi = SEL_WIDTH'(k);
            found_hi = 1'b1;
         end
      end
   end

   assign grant = ((MODE == 0) && found_hi) ? grant_hi : grant_lo;

   always_comb begin
      rdy_o = '0;
      if (!rst_i && load && any_vld) rdy_o[grant] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_o <= 1'b0;
         dat_o <= '0;
         ch_o  <= '0;
         ptr   <= '0;
      end else if (load) begin
         if (any_vld) begin
            vld_o <= 1'b1;
            dat_o <= dat_i[grant];
            ch_o  <= grant;
            // Explicit wrap keeps non-power-of-2 channel counts in range.
            ptr   <= (grant == SEL_WIDTH'(CH_NUM - 1)) ? '0 : grant + 1'b1;
         end else begin
            vld_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux
//   Three instances: 4ch/8b round-robin, 4ch/8b fixed priority, 3ch/16b
//   round-robin. Directed steps then random protocol-respecting traffic,
//   all compared cycle by cycle against a behavioural model.
module tb_rr_arb_mux;

   logic clk;
   logic rst;

   logic [3:0]  v [3];
   logic [15:0] d [3][4];
   logic        r [3];

   logic [3:0]       vld0, vld1;
   logic [2:0]       vld2;
   logic [3:0][7:0]  dat0, dat1;
   logic [2:0][15:0] dat2;
   logic [3:0]       rdy0, rdy1;
   logic [2:0]       rdy2;
   logic             ov0, ov1, ov2;
   logic [7:0]       od0, od1;
   logic [15:0]      od2;
   logic [1:0]       oc0, oc1, oc2;

   logic [3:0]  ordy [3];
   logic        ovld [3];
   logic [15:0] odat [3];
   logic [1:0]  och  [3];

   assign vld0 = v[0];
   assign vld1 = v[1];
   assign vld2 = v[2][2:0];

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         dat0[k] = d[0][k][7:0];
         dat1[k] = d[1][k][7:0];
      end
      for (int k = 0; k < 3; k++) dat2[k] = d[2][k];
   end

   always_comb begin
      ordy[0] = rdy0;
      ordy[1] = rdy1;
      ordy[2] = {1'b0, rdy2};
      ovld[0] = ov0;
      ovld[1] = ov1;
      ovld[2] = ov2;
      odat[0] = {8'h00, od0};
      odat[1] = {8'h00, od1};
      odat[2] = od2;
      och[0]  = oc0;
      och[1]  = oc1;
      och[2]  = oc2;
   end

   rr_arb_mux #(.CH_NUM(4), .DAT_WIDTH(8), .MODE(0)) u_rr4 (
      .clk_i(clk), .rst_i(rst), .vld_i(vld0), .dat_i(dat0), .rdy_o(rdy0),
      .vld_o(ov0), .dat_o(od0), .ch_o(oc0), .rdy_i(r[0]));

   rr_arb_mux #(.CH_NUM(4), .DAT_WIDTH(8), .MODE(1)) u_fp4 (
      .clk_i(clk), .rst_i(rst), .vld_i(vld1), .dat_i(dat1), .rdy_o(rdy1),
      .vld_o(ov1), .dat_o(od1), .ch_o(oc1), .rdy_i(r[1]));

   rr_arb_mux #(.CH_NUM(3), .DAT_WIDTH(16), .MODE(0)) u_rr3 (
      .clk_i(clk), .rst_i(rst), .vld_i(vld2), .dat_i(dat2), .rdy_o(rdy2),
      .vld_o(ov2), .dat_o(od2), .ch_o(oc2), .rdy_i(r[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int n    [3] = '{4, 4, 3};
   int mode [3] = '{0, 1, 0};
   int mask [3] = '{'hFF, 'hFF, 'hFFFF};
   bit mv [3];
   int md [3];
   int mc [3];
   int mp [3];
   logic [3:0] exp_rdy [3];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int id, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s dut%0d: got %0h expected %0h", tag, id, o, e);
      end
   endtask

   // Channel picked by scanning from the pointer around the ring
   // (round-robin) or from 0 (fixed priority); -1 when nothing is valid.
   function automatic int model_grant(input int id);
      for (int i = 0; i < n[id]; i++) begin
         int k;
         k = (mode[id] == 0) ? (mp[id] + i) % n[id] : i;
         if (v[id][k]) return k;
      end
      return -1;
   endfunction

   task automatic tick();
      int g;
      #1;
      for (int id = 0; id < 3; id++) begin
         g = model_grant(id);
         exp_rdy[id] = '0;
         if (!rst && (!mv[id] || r[id]) && g >= 0) exp_rdy[id][g] = 1'b1;
         chk("rdy_o", id, 32'(ordy[id]), 32'(exp_rdy[id]));
      end
      @(posedge clk);
      for (int id = 0; id < 3; id++) begin
         g = model_grant(id);
         if (rst) begin
            mv[id] = 0; md[id] = 0; mc[id] = 0; mp[id] = 0;
         end else if (!mv[id] || r[id]) begin
            if (g >= 0) begin
               mv[id] = 1;
               md[id] = int'(d[id][g]) & mask[id];
               mc[id] = g;
               mp[id] = (g + 1) % n[id];
            end else begin
               mv[id] = 0;
            end
         end
      end
      #1;
      for (int id = 0; id < 3; id++) begin
         chk("vld_o", id, 32'(ovld[id]), 32'(mv[id]));
         chk("dat_o", id, 32'(odat[id]), 32'(md[id]));
         chk("ch_o",  id, 32'(och[id]),  32'(mc[id]));
      end
   endtask

   task automatic set_all(input int id, input logic [3:0] vv, input logic rr);
      v[id] = vv;
      r[id] = rr;
   endtask

   initial begin
      rst = 1'b1;
      for (int id = 0; id < 3; id++) begin
         v[id] = '0;
         r[id] = 1'b0;
         mv[id] = 0; md[id] = 0; mc[id] = 0; mp[id] = 0;
         for (int k = 0; k < 4; k++) d[id][k] = '0;
      end

      // Reset held two cycles, with traffic offered to prove rdy_o stays low
      set_all(0, 4'b1111, 1'b1);
      tick();
      tick();
      chk("reset_vld", 0, 32'(ovld[0]), 32'd0);
      rst = 1'b0;
      set_all(0, 4'b0000, 1'b1);

      // Single source on channel 2
      d[0][2] = 16'h00A5;
      set_all(0, 4'b0100, 1'b1);
      tick();
      chk("t1_dat", 0, 32'(odat[0]), 32'h0A5);
      chk("t1_ch",  0, 32'(och[0]),  32'd2);

      // Round-robin rotation, all channels valid
      for (int k = 0; k < 4; k++) d[0][k] = 16'h10 + 16'(k);
      set_all(0, 4'b1111, 1'b1);
      for (int i = 0; i < 6; i++) tick();

      // Backpressure: five stalled cycles, then release
      set_all(0, 4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      r[0] = 1'b1;
      tick();

      // Fixed priority starvation of channel 3
      for (int k = 0; k < 4; k++) d[1][k] = 16'h20 + 16'(k);
      set_all(1, 4'b1010, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      chk("t4_ch", 1, 32'(och[1]), 32'd1);
      set_all(1, 4'b1000, 1'b1);
      tick();
      chk("t4_ch3", 1, 32'(och[1]), 32'd3);
      set_all(1, 4'b0000, 1'b1);

      // Wrap and skip on 4 and 3 channels
      set_all(0, 4'b1000, 1'b1);
      for (int k = 0; k < 3; k++) d[2][k] = 16'hBEE0 + 16'(k);
      set_all(2, 4'b0100, 1'b1);
      tick();
      set_all(0, 4'b0011, 1'b1);
      set_all(2, 4'b0011, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      chk("t5_ch_rr3", 2, 32'(och[2]), 32'd0);

      // Reset while stalled, then idle drain
      set_all(0, 4'b1111, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_dat", 0, 32'(odat[0]), 32'd0);
      set_all(0, 4'b0001, 1'b1);
      tick();
      set_all(0, 4'b0000, 1'b1);
      tick();
      tick();
      chk("t6_drain_dat", 0, 32'(odat[0]), 32'h10);
      for (int id = 0; id < 3; id++) set_all(id, 4'b0000, 1'b0);

      // Random traffic: a channel keeps vld/dat until its transfer completes
      for (int it = 0; it < 400; it++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int id = 0; id < 3; id++) begin
            for (int k = 0; k < n[id]; k++) begin
               if (!(v[id][k] && !exp_rdy[id][k]) || rst) begin
                  v[id][k] = ($urandom_range(0, 9) < 6);
                  d[id][k] = 16'($urandom) & 16'(mask[id]);
               end
            end
            r[id] = ($urandom_range(0, 9) < 7);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
